// File: rtl/pulse_seq_ctrl.sv
// ============================================================================
// Module   : pulse_seq_ctrl
// Purpose  : Beat sequencer for the pulse monitor: period-counter clear, history shift, fill/valid/lost tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_seq_ctrl #(
  parameter int MIN_PD        = 25,
  parameter int MAX_PD        = 200,
  parameter int TIMEOUT_TICKS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_sp,
  input  logic       tick,
  input  logic [7:0] pd,
  output logic       clr,
  output logic       shift,
  output logic [2:0] fill,
  output logic       valid,
  output logic       lost,
  output logic [3:0] rej_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEAS = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_LOST = 2'd3;

  localparam logic [7:0] C_MIN_PD  = 8'(MIN_PD);
  localparam logic [7:0] C_MAX_PD  = 8'(MAX_PD);
  localparam logic [9:0] C_TO_LAST = 10'(TIMEOUT_TICKS - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] fill_q, fill_d;
  logic       valid_q, valid_d;
  logic       lost_q, lost_d;
  logic [3:0] rej_q, rej_d;
  logic       clr_q, clr_d;
  logic       shift_q, shift_d;
  logic [9:0] to_q, to_d;

  logic w_active;
  logic w_glitch;
  logic w_decide;
  logic w_to_hit;

  assign w_active = (state_q == ST_MEAS) || (state_q == ST_RUN);
  assign w_glitch = pulse_sp && w_active && (pd < C_MIN_PD);
  assign w_decide = pulse_sp && !w_glitch;
  // The tick that brings the count to TIMEOUT_TICKS flips to LOST on the same edge.
  assign w_to_hit = w_active && !clr_q && tick && (to_q == C_TO_LAST);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    lost_d  = lost_q;
    rej_d   = rej_q;
    clr_d   = 1'b0;
    shift_d = 1'b0;
    to_d    = to_q;

    if (clr_q) begin
      to_d = '0;
    end else if (w_active && tick) begin
      to_d = to_q + 10'd1;
    end

    if (w_glitch && (rej_q != 4'hF)) begin
      rej_d = rej_q + 4'd1;
    end

    if (w_decide) begin
      clr_d = 1'b1;
      to_d  = '0;
      if (!w_active) begin
        state_d = ST_MEAS;
        fill_d  = '0;
        valid_d = 1'b0;
        lost_d  = 1'b0;
      end else if (pd <= C_MAX_PD) begin
        shift_d = 1'b1;
        if (fill_q >= 3'd3) begin
          fill_d  = 3'd4;
          valid_d = 1'b1;
          state_d = ST_RUN;
        end else begin
          fill_d  = fill_q + 3'd1;
        end
      end else begin
        state_d = ST_MEAS;
        fill_d  = '0;
        valid_d = 1'b0;
      end
    end else if (w_to_hit) begin
      state_d = ST_LOST;
      lost_d  = 1'b1;
      valid_d = 1'b0;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
      rej_q   <= '0;
      clr_q   <= 1'b0;
      shift_q <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
      rej_q   <= rej_d;
      clr_q   <= clr_d;
      shift_q <= shift_d;
      to_q    <= to_d;
    end
  end

  assign clr     = clr_q;
  assign shift   = shift_q;
  assign fill    = fill_q;
  assign valid   = valid_q;
  assign lost    = lost_q;
  assign rej_cnt = rej_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_seq_ctrl.sv
// ============================================================================
// Module   : tb_pulse_seq_ctrl
// Purpose  : Directed and randomized bench for pulse_seq_ctrl against a beat-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_seq_ctrl;

  localparam int MIN_PD  = 25;
  localparam int MAX_PD  = 200;
  localparam int TIMEOUT = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_sp = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] pd = 8'd0;
  logic       clr, shift, valid, lost;
  logic [2:0] fill;
  logic [3:0] rej_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: beat-level bookkeeping in plain integers.
  int m_seen, m_lost, m_fill, m_valid, m_rej, m_clr, m_shift, m_elapsed;

  always #5 clk = ~clk;

  pulse_seq_ctrl #(.MIN_PD(MIN_PD), .MAX_PD(MAX_PD), .TIMEOUT_TICKS(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pulse_sp(pulse_sp), .tick(tick), .pd(pd),
    .clr(clr), .shift(shift), .fill(fill), .valid(valid), .lost(lost), .rej_cnt(rej_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int r, input int p, input int t, input int v);
    int active, hit, clr_now;
    if (r != 0) begin
      m_seen = 0; m_lost = 0; m_fill = 0; m_valid = 0; m_rej = 0;
      m_clr = 0; m_shift = 0; m_elapsed = 0;
      return;
    end
    active  = (m_seen != 0 && m_lost == 0) ? 1 : 0;
    clr_now = m_clr;
    hit     = (active != 0 && t != 0 && clr_now == 0 && m_elapsed == TIMEOUT - 1) ? 1 : 0;
    m_clr   = 0;
    m_shift = 0;
    if (p != 0 && active == 0) begin
      m_seen = 1; m_lost = 0; m_fill = 0; m_valid = 0; m_clr = 1; m_elapsed = 0;
    end else if (p != 0 && v >= MIN_PD && v <= MAX_PD) begin
      m_fill  = (m_fill + 1 > 4) ? 4 : m_fill + 1;
      m_valid = (m_fill == 4) ? 1 : 0;
      m_clr = 1; m_shift = 1; m_elapsed = 0;
    end else if (p != 0 && v > MAX_PD) begin
      m_fill = 0; m_valid = 0; m_clr = 1; m_elapsed = 0;
    end else begin
      if (p != 0 && m_rej < 15) m_rej++;
      if (hit != 0) begin
        m_lost = 1; m_valid = 0; m_fill = 0;
      end
      if (clr_now != 0) m_elapsed = 0;
      else if (active != 0 && t != 0) m_elapsed++;
    end
  endtask

  task automatic cyc(input logic r, input logic p, input logic t, input logic [7:0] v);
    rst = r; pulse_sp = p; tick = t; pd = v;
    @(posedge clk);
    model_step(int'(r), int'(p), int'(t), int'(v));
    #1;
    check("clr",     int'(clr),     m_clr);
    check("shift",   int'(shift),   m_shift);
    check("fill",    int'(fill),    m_fill);
    check("valid",   int'(valid),   m_valid);
    check("lost",    int'(lost),    m_lost);
    check("rej_cnt", int'(rej_cnt), m_rej);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic beat(input logic [7:0] v);
    gap(4);
    cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), v);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 1'b1, 8'd80);
    check("reset_fill", int'(fill), 0);
    check("reset_clr", int'(clr), 0);

    // Warm-up: first beat clears only, then four accepted beats fill the history.
    beat(8'd80);
    check("first_clr", int'(clr), 1);
    check("first_shift", int'(shift), 0);
    for (int k = 1; k <= 4; k++) begin
      beat(8'd80);
      check("warm_shift", int'(shift), 1);
      check("warm_fill", int'(fill), k);
    end
    check("warm_valid", int'(valid), 1);

    beat(8'd10);
    check("glitch_rej", int'(rej_cnt), 1);
    check("glitch_clr", int'(clr), 0);
    beat(8'd80);
    check("run_fill", int'(fill), 4);
    check("run_valid", int'(valid), 1);

    beat(8'd220);
    check("miss_fill", int'(fill), 0);
    check("miss_valid", int'(valid), 0);
    check("miss_clr", int'(clr), 1);
    for (int k = 0; k < 4; k++) beat(8'd80);
    check("restore_valid", int'(valid), 1);

    // Boundary classification values.
    beat(8'd24);  check("pd24_clr", int'(clr), 0);
    beat(8'd25);  check("pd25_shift", int'(shift), 1);
    beat(8'd200); check("pd200_shift", int'(shift), 1);
    beat(8'd201); check("pd201_shift", int'(shift), 0);
    beat(8'd255); check("pd255_fill", int'(fill), 0);
    for (int k = 0; k < 4; k++) beat(8'd80);

    // Timeout with a tick every cycle.
    for (int i = 0; i < TIMEOUT + 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'd255);
    check("to_lost", int'(lost), 1);
    check("to_valid", int'(valid), 0);
    beat(8'd80);
    check("relock_lost", int'(lost), 0);
    check("relock_clr", int'(clr), 1);

    // Pulse on the timeout-reaching tick wins.
    while (m_elapsed < TIMEOUT - 1) cyc(1'b0, 1'b0, 1'b1, 8'd90);
    cyc(1'b0, 1'b1, 1'b1, 8'd80);
    check("race_lost", int'(lost), 0);
    check("race_shift", int'(shift), 1);
    // A glitch on the timeout-reaching tick does not rescue it.
    while (m_elapsed < TIMEOUT - 1) cyc(1'b0, 1'b0, 1'b1, 8'd90);
    cyc(1'b0, 1'b1, 1'b1, 8'd5);
    check("glitch_race_lost", int'(lost), 1);

    beat(8'd80);
    for (int k = 0; k < 20; k++) beat(8'd5);
    check("rej_sat", int'(rej_cnt), 15);
    cyc(1'b0, 1'b1, 1'b1, 8'd80);
    check("coinc_shift", int'(shift), 1);

    // Reset mid-interval with fill = 3.
    beat(8'd220); beat(8'd80); beat(8'd80); beat(8'd80);
    check("pre_rst_fill", int'(fill), 3);
    gap(2);
    cyc(1'b1, 1'b0, 1'b1, 8'd80);
    check("rst_fill", int'(fill), 0);
    check("rst_rej", int'(rej_cnt), 0);
    beat(8'd80);
    check("post_rst_shift", int'(shift), 0);
    check("post_rst_clr", int'(clr), 1);

    // Randomized traffic with occasional quiet stretches and resets.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 1200; i++) begin
        int sel;
        logic [7:0] v;
        sel = int'($urandom_range(0, 9));
        if (sel < 2)      v = 8'($urandom_range(0, MIN_PD - 1));
        else if (sel < 8) v = 8'($urandom_range(MIN_PD, MAX_PD));
        else              v = 8'($urandom_range(MAX_PD + 1, 255));
        cyc(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), v);
      end
      for (int i = 0; i < 700; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
